// File: rtl/pwm_receiver.sv
// pwm_receiver: decodes four RC-style PWM pulse trains into 8-bit throttle commands.
// Each channel is synchronised, measured in whole microseconds, range-checked and
// watched by a signal-loss timeout. Throttle = min(255, (width_us - MIN_US) >> 2),
// or 0 for pulses shorter than MIN_US.
// Optional feature: define PWM_RX_DEGLITCH_EN to add a per-channel stability filter
// (DEGLITCH_CYCLES) between the synchroniser and the edge detector.
module pwm_receiver #(
    parameter int unsigned CLK_PER_US      = 50,
    parameter int unsigned MIN_US          = 1000,
    parameter int unsigned MAX_PULSE_US    = 2500,
    parameter int unsigned TIMEOUT_US      = 25000,
    parameter int unsigned DEGLITCH_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] pwm_in,
    output logic [7:0] throttle1,
    output logic [7:0] throttle2,
    output logic [7:0] throttle3,
    output logic [7:0] throttle4,
    output logic [3:0] valid,
    output logic [3:0] update,
    output logic [3:0] error
);

    localparam int unsigned SubW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [SubW-1:0] SubLast = SubW'(CLK_PER_US - 1);
    localparam logic [11:0] MinUs  = 12'(MIN_US);
    localparam logic [11:0] MaxUs  = 12'(MAX_PULSE_US);
    localparam logic [14:0] ToUs   = 15'(TIMEOUT_US);
    localparam logic [14:0] ToLast = 15'(TIMEOUT_US - 1);

    typedef enum logic [1:0] {
        StWaitRise = 2'd0,
        StHigh     = 2'd1,
        StWaitFall = 2'd2
    } state_e;

    // Width in microseconds to throttle code, saturating at 255.
    function automatic logic [7:0] to_throttle(input logic [11:0] w);
        logic [9:0] steps;
        if (w < MinUs) begin
            return 8'd0;
        end
        steps = 10'((w - MinUs) >> 2);
        return (steps > 10'd255) ? 8'hFF : steps[7:0];
    endfunction

    // ------------------------------------------------------------------
    // Shared microsecond prescaler for the timeout counters
    // ------------------------------------------------------------------
    logic [SubW-1:0] pre_q, pre_d;
    logic            us_tick;

    // Free-running divider producing one tick per microsecond.
    always_comb begin
        us_tick = (pre_q == SubLast);
        pre_d   = us_tick ? '0 : pre_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // ------------------------------------------------------------------
    // Synchroniser. Reset to 1 so a pin already high at reset release does
    // not look like a rising edge; the partial pulse is thereby ignored.
    // ------------------------------------------------------------------
    logic [3:0] meta_q, sync_q;
    logic [3:0] s;

    // Two-flop synchroniser on the raw pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= pwm_in;
            sync_q <= meta_q;
        end
    end

`ifdef PWM_RX_DEGLITCH_EN
    localparam int unsigned DgW = (DEGLITCH_CYCLES > 1) ? $clog2(DEGLITCH_CYCLES) : 1;
    localparam logic [DgW-1:0] DgLast = DgW'(DEGLITCH_CYCLES - 1);

    logic [3:0]     filt_q, filt_d;
    logic [DgW-1:0] dg_cnt_q [4];
    logic [DgW-1:0] dg_cnt_d [4];

    // Filtered level follows the synchroniser only after it has differed for
    // DEGLITCH_CYCLES consecutive clocks.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 4; i++) begin
            dg_cnt_d[i] = '0;
            if (sync_q[i] != filt_q[i]) begin
                if (dg_cnt_q[i] == DgLast) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    dg_cnt_d[i] = dg_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Deglitch filter state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '1;
            for (int i = 0; i < 4; i++) begin
                dg_cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 4; i++) begin
                dg_cnt_q[i] <= dg_cnt_d[i];
            end
        end
    end

    assign s = filt_q;
`else
    assign s = sync_q;
`endif

    // ------------------------------------------------------------------
    // Edge detection against a registered copy of s; edges are registered
    // so the measurement and the load both see them one clock later.
    // ------------------------------------------------------------------
    logic [3:0] s_prev_q;
    logic [3:0] rise_q, rise_d;
    logic [3:0] fall_q, fall_d;

    // Rising/falling edge decode.
    always_comb begin
        rise_d = s & ~s_prev_q;
        fall_d = ~s & s_prev_q;
    end

    // Edge-detect registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_prev_q <= '1;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            s_prev_q <= s;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel measurement FSM, throttle register and timeout
    // ------------------------------------------------------------------
    state_e          state_q [4];
    state_e          state_d [4];
    logic [SubW-1:0] sub_q   [4];
    logic [SubW-1:0] sub_d   [4];
    logic [11:0]     width_q [4];
    logic [11:0]     width_d [4];
    logic [7:0]      thr_q   [4];
    logic [7:0]      thr_d   [4];
    logic [14:0]     to_q    [4];
    logic [14:0]     to_d    [4];
    logic [3:0]      valid_q, valid_d;
    logic [3:0]      update_q, update_d;
    logic [3:0]      error_q, error_d;
    logic [3:0]      wrap;
    logic [11:0]     width_inc [4];

    // Next-state, measurement and output decode for all four channels.
    always_comb begin
        valid_d  = valid_q;
        update_d = '0;
        error_d  = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            sub_d[i]   = sub_q[i];
            width_d[i] = width_q[i];
            thr_d[i]   = thr_q[i];
            to_d[i]    = to_q[i];

            // Width including the current high cycle, so the final count on
            // the falling edge covers every high clock.
            wrap[i]      = (sub_q[i] == SubLast);
            width_inc[i] = width_q[i] + 12'(wrap[i]);

            unique case (state_q[i])
                StWaitRise: begin
                    if (rise_q[i]) begin
                        sub_d[i]   = '0;
                        width_d[i] = '0;
                        state_d[i] = StHigh;
                    end
                end
                StHigh: begin
                    sub_d[i]   = wrap[i] ? '0 : sub_q[i] + 1'b1;
                    width_d[i] = width_inc[i];
                    if (fall_q[i]) begin
                        state_d[i]  = StWaitRise;
                        thr_d[i]    = to_throttle(width_inc[i]);
                        update_d[i] = 1'b1;
                        valid_d[i]  = 1'b1;
                    end else if (width_inc[i] > MaxUs) begin
                        error_d[i] = 1'b1;
                        state_d[i] = StWaitFall;
                    end
                end
                StWaitFall: begin
                    if (fall_q[i]) begin
                        state_d[i] = StWaitRise;
                    end
                end
                default: begin
                    state_d[i] = StWaitRise;
                end
            endcase

            // Signal-loss timeout; a coincident update takes priority.
            if (update_d[i]) begin
                to_d[i] = '0;
            end else if (us_tick && (to_q[i] < ToUs)) begin
                to_d[i] = to_q[i] + 15'd1;
                if (to_q[i] == ToLast) begin
                    valid_d[i] = 1'b0;
                    thr_d[i]   = 8'd0;
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= StWaitRise;
                sub_q[i]   <= '0;
                width_q[i] <= '0;
                thr_q[i]   <= '0;
                to_q[i]    <= '0;
            end
            valid_q  <= '0;
            update_q <= '0;
            error_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                sub_q[i]   <= sub_d[i];
                width_q[i] <= width_d[i];
                thr_q[i]   <= thr_d[i];
                to_q[i]    <= to_d[i];
            end
            valid_q  <= valid_d;
            update_q <= update_d;
            error_q  <= error_d;
        end
    end

    // Channel 1 is pin bit 3, channel 4 is pin bit 0.
    assign throttle1 = thr_q[3];
    assign throttle2 = thr_q[2];
    assign throttle3 = thr_q[1];
    assign throttle4 = thr_q[0];
    assign valid     = valid_q;
    assign update    = update_q;
    assign error     = error_q;

endmodule

// File: tb/tb_pwm_receiver.sv
// Testbench for pwm_receiver. Runs with a scaled-down clock rate and timeout so the
// whole plan fits in a short simulation; pulse widths are in real microseconds.
module tb_pwm_receiver;

    localparam int unsigned CLK  = 2;     // cycles per microsecond in this bench
    localparam int unsigned MINU = 1000;
    localparam int unsigned MAXU = 2500;
    localparam int unsigned TOU  = 6000;
    localparam int unsigned DG   = 4;
`ifdef PWM_RX_DEGLITCH_EN
    localparam int LAT = 4;  // model's filtered-sample event to output register
`else
    localparam int LAT = 3;  // first pin sample to output register
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] pwm_in  = 4'h0;
    logic [7:0] throttle1, throttle2, throttle3, throttle4;
    logic [3:0] valid, update, error;

    always #5 clock = ~clock;

    pwm_receiver #(
        .CLK_PER_US      (CLK),
        .MIN_US          (MINU),
        .MAX_PULSE_US    (MAXU),
        .TIMEOUT_US      (TOU),
        .DEGLITCH_CYCLES (DG)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pwm_in    (pwm_in),
        .throttle1 (throttle1),
        .throttle2 (throttle2),
        .throttle3 (throttle3),
        .throttle4 (throttle4),
        .valid     (valid),
        .update    (update),
        .error     (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: works from the pin levels the bench drives.
    // A pulse of N high samples gives width floor(N/CLK) us; results appear
    // a fixed latency after the sample that ends (or overflows) the pulse.
    // The microsecond tick falls on every CLK-th clock after reset release.
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        int         ch;
        bit         is_err;
        logic [7:0] val;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] m_thr [4];
    logic [3:0] m_valid, m_upd, m_err;
    int         m_tcnt [4];
    int         m_hi   [4];
    bit         m_prev [4];
    bit         m_live [4];
    bit         m_filt [4];
    int         m_run  [4];
    int         g;

    function automatic logic [7:0] expect_thr(input int us);
        int t;
        if (us < int'(MINU)) return 8'd0;
        t = (us - int'(MINU)) / 4;
        return (t > 255) ? 8'd255 : 8'(t);
    endfunction

    task automatic model_reset();
        ev_q.delete();
        g       = 0;
        m_valid = '0;
        m_upd   = '0;
        m_err   = '0;
        for (int c = 0; c < 4; c++) begin
            m_thr[c]  = 8'd0;
            m_tcnt[c] = 0;
            m_hi[c]   = 0;
            m_prev[c] = 1'b1;  // a pin high at reset release is not a new pulse
            m_live[c] = 1'b0;
            m_filt[c] = 1'b1;
            m_run[c]  = 0;
        end
    endtask

    task automatic model_step();
        bit   got [4];
        bit   p;
        ev_t  e;
        g++;
        m_upd = '0;
        m_err = '0;
        for (int c = 0; c < 4; c++) got[c] = 1'b0;
        for (int k = ev_q.size() - 1; k >= 0; k--) begin
            if (ev_q[k].due == g) begin
                if (ev_q[k].is_err) begin
                    m_err[ev_q[k].ch] = 1'b1;
                end else begin
                    m_upd[ev_q[k].ch]   = 1'b1;
                    m_valid[ev_q[k].ch] = 1'b1;
                    m_thr[ev_q[k].ch]   = ev_q[k].val;
                    m_tcnt[ev_q[k].ch]  = 0;
                    got[ev_q[k].ch]     = 1'b1;
                end
                ev_q.delete(k);
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (!got[c] && (g % int'(CLK) == 0) && m_tcnt[c] < int'(TOU)) begin
                m_tcnt[c]++;
                if (m_tcnt[c] == int'(TOU)) begin
                    m_valid[c] = 1'b0;
                    m_thr[c]   = 8'd0;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
`ifdef PWM_RX_DEGLITCH_EN
            if (pwm_in[c] != m_filt[c]) begin
                m_run[c]++;
                if (m_run[c] == int'(DG)) begin
                    m_filt[c] = pwm_in[c];
                    m_run[c]  = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            p = m_filt[c];
`else
            p = pwm_in[c];
`endif
            if (p && !m_prev[c]) begin
                m_live[c] = 1'b1;
                m_hi[c]   = 1;
            end else if (p && m_live[c]) begin
                m_hi[c]++;
                if (m_hi[c] == int'((MAXU + 1) * CLK) + 1) begin
                    e = '{due: g + LAT, ch: c, is_err: 1'b1, val: 8'd0};
                    ev_q.push_back(e);
                    m_live[c] = 1'b0;
                end
            end else if (!p && m_prev[c] && m_live[c]) begin
                e = '{due: g + LAT, ch: c, is_err: 1'b0,
                      val: expect_thr(m_hi[c] / int'(CLK))};
                ev_q.push_back(e);
                m_live[c] = 1'b0;
            end
            m_prev[c] = p;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n && n_fail < 50) begin
                check("cycle_outputs",
                      {throttle1, throttle2, throttle3, throttle4, valid, update, error},
                      {m_thr[3], m_thr[2], m_thr[1], m_thr[0], m_valid, m_upd, m_err});
            end
        end
    end

    // Strobe counters observed from the DUT.
    int n_upd [4] = '{0, 0, 0, 0};
    int n_err [4] = '{0, 0, 0, 0};
    int n_all4    = 0;

    initial begin
        forever begin
            @(negedge clock);
            for (int c = 0; c < 4; c++) begin
                if (update[c]) n_upd[c]++;
                if (error[c]) n_err[c]++;
            end
            if (update == 4'hF) n_all4++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic gap(input int us);
        repeat (us * int'(CLK)) @(posedge clock);
    endtask

    task automatic pulse(input int ch, input int us);
        @(posedge clock);
        #2 pwm_in[ch] = 1'b1;
        repeat (us * int'(CLK)) @(posedge clock);
        #2 pwm_in[ch] = 1'b0;
    endtask

    // One channel-1 pulse with literal expectations on the result.
    task automatic send1(input string name, input int us, input logic [7:0] exp_thr);
        int u0;
        u0 = n_upd[3];
        pulse(3, us);
        gap(20);
        @(negedge clock);
        check({name, "_thr"}, throttle1, exp_thr);
        check({name, "_upd_count"}, n_upd[3] - u0, 1);
        check({name, "_valid"}, valid[3], 1'b1);
    endtask

    int u0, e0, a0;
    int u4 [4];

    initial begin
        // Reset state
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("reset_outputs",
              {throttle1, throttle2, throttle3, throttle4, valid, update, error}, 44'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        gap(50);

        // Reset asserted mid-pulse; partial pulse after release is ignored
        @(posedge clock);
        #2 pwm_in[3] = 1'b1;
        gap(300);
        @(posedge clock);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_mid_pulse_outputs",
              {throttle1, throttle2, throttle3, throttle4, valid, update, error}, 44'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        gap(500);
        @(posedge clock);
        #2 pwm_in[3] = 1'b0;
        gap(20);
        @(negedge clock);
        check("partial_pulse_no_update", n_upd[3], 0);
        check("partial_pulse_valid", valid[3], 1'b0);
        send1("after_reset_1500", 1500, 8'd125);

        // Range mapping
        send1("map_1000", 1000, 8'd0);
        send1("map_1500", 1500, 8'd125);
        send1("map_2020", 2020, 8'd255);
        send1("map_2100", 2100, 8'd255);

        // Short pulse
        send1("short_900", 900, 8'd0);

        // Over-long pulse: error once, throttle kept, no update
        send1("pre_long_1500", 1500, 8'd125);
        u0 = n_upd[3];
        e0 = n_err[3];
        pulse(3, 3000);
        gap(20);
        @(negedge clock);
        check("long_err_count", n_err[3] - e0, 1);
        check("long_upd_count", n_upd[3] - u0, 0);
        check("long_thr_kept", throttle1, 8'd125);

        // Timeout
        send1("pre_timeout_1500", 1500, 8'd125);
        gap(TOU - 100);
        @(negedge clock);
        check("before_timeout_valid", valid[3], 1'b1);
        gap(200);
        @(negedge clock);
        check("timeout_valid", valid[3], 1'b0);
        check("timeout_thr", throttle1, 8'd0);
        send1("recover_1200", 1200, 8'd50);

        // Four channels, staggered rises, coincident falls
        for (int c = 0; c < 4; c++) u4[c] = n_upd[c];
        a0 = n_all4;
        @(posedge clock);
        #2 pwm_in[0] = 1'b1;
        gap(300);
        #2 pwm_in[1] = 1'b1;
        gap(300);
        #2 pwm_in[2] = 1'b1;
        gap(300);
        #2 pwm_in[3] = 1'b1;
        gap(1100);
        #2 pwm_in = 4'h0;
        gap(20);
        @(negedge clock);
        check("multi_thr1", throttle1, 8'd25);
        check("multi_thr2", throttle2, 8'd100);
        check("multi_thr3", throttle3, 8'd175);
        check("multi_thr4", throttle4, 8'd250);
        check("multi_valid", valid, 4'hF);
        check("multi_simultaneous", n_all4 - a0, 1);
        for (int c = 0; c < 4; c++) check("multi_upd_count", n_upd[c] - u4[c], 1);

`ifdef PWM_RX_DEGLITCH_EN
        // Two-cycle low glitch inside a 1500 us pulse
        u0 = n_upd[3];
        @(posedge clock);
        #2 pwm_in[3] = 1'b1;
        repeat (750 * CLK) @(posedge clock);
        #2 pwm_in[3] = 1'b0;
        repeat (2) @(posedge clock);
        #2 pwm_in[3] = 1'b1;
        repeat (750 * CLK - 2) @(posedge clock);
        #2 pwm_in[3] = 1'b0;
        gap(20);
        @(negedge clock);
        check("glitch_thr", throttle1, 8'd125);
        check("glitch_upd_count", n_upd[3] - u0, 1);
`endif

        gap(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
